ddr3_cmd_responder: RTL and testbench
=====================================

# ddr3_cmd_responder

Device-side responder for the DDR3 command bus driven by the controller state machine. It decodes CS/RAS/CAS/WE each clock and tracks per-bank open/closed state and open rows. It checks tRCD/tRP/tRFC timing, stores written data in a small masked array, and returns read data after CAS latency. It serves as the memory model and protocol checker that closes the loop on the controller in simulation and on-FPGA loopback.

## Interface
- CL, 5: read latency in cycles, from READ command cycle to DQ_valid; legal 1..15
- CWL, 0: write latency in cycles, from WRITE command cycle to DQ_in/LDM/UDM sampling; legal 0..7
- tRCD, 4: minimum cycles from ACT to READ/WRITE on the same bank
- tRP, 4: minimum cycles from PRE (or auto-precharge) to ACT on the same bank
- tRFC, 10: cycles after REF during which only NOP/DESELECT are legal
- MEM_AW, 8: storage address width, 2^MEM_AW x 16-bit words; legal 7..12

- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  reset; synchronous, active-high
- CS, RAS, CAS, WE  in  1 each  command pins, active-low
- Addr_in  in  15  row on ACT; column on RD/WR (A10 = auto-precharge, A12 ignored); A10 on PRE
- BA_in  in  3  bank address
- LDM, UDM  in  1 each  byte masks; 1 = byte not written
- DQ_in  in  16  write data
- DQ_out  out  16  read data; valid when DQ_valid = 1
- DQ_valid  out  1  one-cycle strobe per READ
- bank_open  out  8  bit b = 1 while bank b is open
- refreshing  out  1  high during the tRFC window
- err  out  1  one-cycle pulse on an illegal command
- err_code  out  3  reason code, held until the next err

## Operation
- Decode with CS=0, as {RAS,CAS,WE}:
  - 111 NOP
  - 011 ACT
  - 101 READ
  - 100 WRITE
  - 010 PRE
  - 001 REF
  - 000 MRS
  - 110 ZQCL
- CS=1 is DESELECT, treated as NOP. MRS and ZQCL are accepted and have no effect.
- Per-bank FSM with states CLOSED, ACTIVE, PRECHARGING:
  - ACT in CLOSED: latch Addr_in as row; load tRCD counter; go to ACTIVE.
  - PRE (A10=0 bank BA_in; A10=1 all banks): each open target bank goes to PRECHARGING and loads tRP. PRE to a closed bank is legal and a no-op.
  - READ/WRITE with A10=1 (auto-precharge): the access completes, then the bank goes to PRECHARGING in the same cycle.
  - PRECHARGING returns to CLOSED when the tRP count expires.
- Storage index = {BA_in, row[MEM_AW-7:0], col[2:0]}.
  - WRITE: compute the index at the command cycle, then commit DQ_in bytes not masked by LDM/UDM CWL cycles later.
  - READ: compute the index at the command cycle, then read the array.
- Error codes; the erroneous command is dropped, with no state change and no write:
  - 1: ACT to an ACTIVE bank
  - 2: READ/WRITE to a non-ACTIVE bank
  - 3: READ/WRITE before tRCD expired
  - 4: ACT to a PRECHARGING bank
  - 5: REF with any bank not CLOSED
  - 6: any non-NOP command while refreshing
- Priority: code 6 is checked first, then the per-command checks.
- Storage contents are not reset.

## Timing
- Reset values: DQ_out=0, DQ_valid=0, bank_open=0, refreshing=0, err=0, err_code=0. All banks CLOSED, all counters 0.
- Reset flushes the read and write pipelines. Writes in flight are discarded.
- A READ at cycle t gives DQ_valid=1 and DQ_out at t+CL. Back-to-back READs give back-to-back valid strobes.
- A WRITE at t with CWL=0 commits at t. A READ at t+1 to the same index returns the new data.
- A write committing in the same cycle as a read array access: the read returns the new data (write-first).
- Timer semantics: ACT at t allows READ/WRITE from t+tRCD. PRE at t allows ACT from t+tRP.
- REF at t: refreshing is high for cycles t+1 through t+tRFC. A REF at t+tRFC+1 is legal.
- bank_open reflects ACTIVE state only. It rises the cycle after ACT and falls the cycle after PRE or auto-precharge.
- err and err_code register one cycle after the offending command.

## Structure
- Package ddr3_pkg holds:
  - command encodings
  - the bank-state enum
  - error code constants
  - default timing constants (shared with the controller's tRFC)
- Sub-module ddr3_bank_tracker, instantiated 8 times. It holds the per-bank FSM, row register, and a 4-bit timer, and takes decoded ACT/PRE/RDWR-AP strobes.
- The top level holds the decode, error priority, storage array, and CL/CWL shift pipes.

## Test plan
- Reset, then ACT bank 0 row 0x0001; wait 4 cycles; WRITE col 0x005 with DQ_in=0xA5C3, LDM=UDM=0; READ col 0x005. Expect DQ_out=0xA5C3 with DQ_valid exactly 5 cycles after the READ.
- Start from a word holding 0xA5C3. WRITE 0x1234 with LDM=1, UDM=0, then READ. Expect 0x12C3.
- READ to a closed bank 3: expect err=1, err_code=2, no DQ_valid. Then ACT bank 3 and READ 2 cycles later: expect err_code=3.
- WRITE with A10=1: bank_open[0] falls. ACT bank 0 at 2 cycles after the WRITE: expect err_code=4. ACT at 4 cycles after the WRITE: accepted, bank_open[0]=1.
- With all banks closed, REF: refreshing high for 10 cycles. ACT during the window: expect err_code=6. REF while bank 2 is open: expect err_code=5.
- Assert RESET while 3 READs are in flight: expect no DQ_valid afterwards, bank_open=0, and previously written data intact on re-read.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared DDR3 command-bus definitions: command encodings, bank states,
// responder error codes and default timing shared with the controller.
package ddr3_pkg;

  localparam int unsigned NUM_BANKS = 8;
  localparam int unsigned BA_W      = 3;
  localparam int unsigned ROW_W     = 15;
  localparam int unsigned DQ_W      = 16;
  localparam int unsigned TMR_W     = 4;

  localparam int unsigned DEF_CL     = 5;
  localparam int unsigned DEF_CWL    = 0;
  localparam int unsigned DEF_TRCD   = 4;
  localparam int unsigned DEF_TRP    = 4;
  localparam int unsigned DEF_TRFC   = 10;
  localparam int unsigned DEF_MEM_AW = 8;

  // {RAS,CAS,WE} with CS low
  typedef enum logic [2:0] {
    CMD_MRS  = 3'b000,
    CMD_REF  = 3'b001,
    CMD_PRE  = 3'b010,
    CMD_ACT  = 3'b011,
    CMD_WR   = 3'b100,
    CMD_RD   = 3'b101,
    CMD_ZQCL = 3'b110,
    CMD_NOP  = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    BANK_CLOSED      = 2'd0,
    BANK_ACTIVE      = 2'd1,
    BANK_PRECHARGING = 2'd2
  } bank_state_e;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN   = 3'd1;
  localparam logic [2:0] ERR_NOT_ACTIVE = 3'd2;
  localparam logic [2:0] ERR_TRCD       = 3'd3;
  localparam logic [2:0] ERR_ACT_PRECHG = 3'd4;
  localparam logic [2:0] ERR_REF_OPEN   = 3'd5;
  localparam logic [2:0] ERR_REFRESHING = 3'd6;

  // Timer reload so that an event at t is allowed again at t+cycles.
  function automatic logic [TMR_W-1:0] timer_load(input int unsigned cycles);
    if (cycles > 1) return TMR_W'(cycles - 1);
    return '0;
  endfunction

endpackage

// File: rtl/ddr3_bank_tracker.sv
// Per-bank open/closed tracker: FSM, open row and a shared tRCD/tRP timer.
module ddr3_bank_tracker
  import ddr3_pkg::*;
#(
  parameter int unsigned T_RCD = DEF_TRCD,
  parameter int unsigned T_RP  = DEF_TRP
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             act_i,
  input  logic             pre_i,
  input  logic             ap_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [1:0]       state_o,
  output logic [ROW_W-1:0] row_o,
  output logic [TMR_W-1:0] timer_o,
  output logic             open_o
);

  localparam logic [TMR_W-1:0] RCD_LOAD = timer_load(T_RCD);
  localparam logic [TMR_W-1:0] RP_LOAD  = timer_load(T_RP);

  bank_state_e      state_q;
  logic [ROW_W-1:0] row_q;
  logic [TMR_W-1:0] timer_q;
  logic             open_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BANK_CLOSED;
      row_q   <= '0;
      timer_q <= '0;
      open_q  <= 1'b0;
    end else begin
      if (timer_q != '0) timer_q <= timer_q - TMR_W'(1);
      case (state_q)
        BANK_CLOSED: begin
          if (act_i) begin
            state_q <= BANK_ACTIVE;
            row_q   <= row_i;
            timer_q <= RCD_LOAD;
            open_q  <= 1'b1;
          end
        end
        BANK_ACTIVE: begin
          if (pre_i || ap_i) begin
            if (T_RP > 1) state_q <= BANK_PRECHARGING;
            else          state_q <= BANK_CLOSED;
            timer_q <= RP_LOAD;
            open_q  <= 1'b0;
          end
        end
        BANK_PRECHARGING: begin
          // leave one cycle early so ACT at PRE+tRP sees CLOSED
          if (timer_q <= TMR_W'(1)) state_q <= BANK_CLOSED;
        end
        default: state_q <= BANK_CLOSED;
      endcase
    end
  end

  assign state_o = state_q;
  assign row_o   = row_q;
  assign timer_o = timer_q;
  assign open_o  = open_q;

endmodule

// File: rtl/ddr3_cmd_responder.sv
// DDR3 device-side responder: command decode, protocol checks, masked
// storage and CL/CWL pipelines closing the loop on the controller.
module ddr3_cmd_responder
  import ddr3_pkg::*;
#(
  parameter int unsigned CL     = DEF_CL,
  parameter int unsigned CWL    = DEF_CWL,
  parameter int unsigned tRCD   = DEF_TRCD,
  parameter int unsigned tRP    = DEF_TRP,
  parameter int unsigned tRFC   = DEF_TRFC,
  parameter int unsigned MEM_AW = DEF_MEM_AW
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [14:0] Addr_in,
  input  logic [2:0]  BA_in,
  input  logic        LDM,
  input  logic        UDM,
  input  logic [15:0] DQ_in,
  output logic [15:0] DQ_out,
  output logic        DQ_valid,
  output logic [7:0]  bank_open,
  output logic        refreshing,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int unsigned RFC_W  = (tRFC < 2) ? 1 : $clog2(tRFC + 1);
  localparam int unsigned RSEL_W = MEM_AW - 6;
  localparam int unsigned DEPTH  = 1 << MEM_AW;

  logic [1:0]           bank_state [NUM_BANKS];
  logic [ROW_W-1:0]     bank_row   [NUM_BANKS];
  logic [TMR_W-1:0]     bank_timer [NUM_BANKS];
  logic [NUM_BANKS-1:0] act_c, pre_c, ap_c;

  cmd_e              cmd_c;
  logic [2:0]        code_c;
  logic              any_busy_c, cmd_ok_c, rd_go_c, wr_go_c;
  logic [MEM_AW-1:0] idx_c;
  logic              wr_commit_c;
  logic [MEM_AW-1:0] wr_idx_c;
  logic [DQ_W-1:0]   rd_word_c;
  logic [RFC_W-1:0]  rfc_d, rfc_q;
  logic              unused_row_bits;

  logic [DQ_W-1:0]   mem [DEPTH];
  logic [CL-1:0]     rd_vld_q;
  logic [DQ_W-1:0]   rd_dat_q [CL];
  logic              err_q, refreshing_q;
  logic [2:0]        err_code_q;

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    ddr3_bank_tracker #(.T_RCD(tRCD), .T_RP(tRP)) u_bank (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .act_i   (act_c[gb]),
      .pre_i   (pre_c[gb]),
      .ap_i    (ap_c[gb]),
      .row_i   (Addr_in),
      .state_o (bank_state[gb]),
      .row_o   (bank_row[gb]),
      .timer_o (bank_timer[gb]),
      .open_o  (bank_open[gb])
    );
  end

  // Decode and error priority; refresh lockout dominates all per-command checks.
  always_comb begin
    cmd_c      = CS ? CMD_NOP : cmd_e'({RAS, CAS, WE});
    any_busy_c = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) any_busy_c |= (bank_state[b] != BANK_CLOSED);
    code_c = ERR_NONE;
    if (refreshing_q && cmd_c != CMD_NOP) begin
      code_c = ERR_REFRESHING;
    end else begin
      case (cmd_c)
        CMD_ACT: begin
          if (bank_state[BA_in] == BANK_ACTIVE)           code_c = ERR_ACT_OPEN;
          else if (bank_state[BA_in] == BANK_PRECHARGING) code_c = ERR_ACT_PRECHG;
        end
        CMD_RD, CMD_WR: begin
          if (bank_state[BA_in] != BANK_ACTIVE) code_c = ERR_NOT_ACTIVE;
          else if (bank_timer[BA_in] != '0)     code_c = ERR_TRCD;
        end
        CMD_REF: if (any_busy_c) code_c = ERR_REF_OPEN;
        default: ;
      endcase
    end
    cmd_ok_c = (code_c == ERR_NONE);
    rd_go_c  = cmd_ok_c && (cmd_c == CMD_RD);
    wr_go_c  = cmd_ok_c && (cmd_c == CMD_WR);
    act_c = '0;
    pre_c = '0;
    ap_c  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      act_c[b] = cmd_ok_c && (cmd_c == CMD_ACT) && (BA_in == 3'(b));
      pre_c[b] = cmd_ok_c && (cmd_c == CMD_PRE) && (Addr_in[10] || BA_in == 3'(b));
      ap_c[b]  = (rd_go_c || wr_go_c) && Addr_in[10] && (BA_in == 3'(b));
    end
    idx_c = {BA_in, bank_row[BA_in][RSEL_W-1:0], Addr_in[2:0]};
  end

  always_comb begin
    unused_row_bits = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) unused_row_bits ^= ^bank_row[b][ROW_W-1:RSEL_W];
  end

  if (CWL == 0) begin : g_wr_direct
    assign wr_commit_c = wr_go_c;
    assign wr_idx_c    = idx_c;
  end else begin : g_wr_pipe
    logic [CWL-1:0]    vld_q;
    logic [MEM_AW-1:0] idx_q [CWL];
    always_ff @(posedge CLK) begin
      if (RESET) vld_q <= '0;
      else begin
        vld_q[0] <= wr_go_c;
        for (int i = 1; i < CWL; i++) vld_q[i] <= vld_q[i-1];
      end
      idx_q[0] <= idx_c;
      for (int i = 1; i < CWL; i++) idx_q[i] <= idx_q[i-1];
    end
    assign wr_commit_c = vld_q[CWL-1];
    assign wr_idx_c    = idx_q[CWL-1];
  end

  // Storage is deliberately left unreset; masked bytes keep their old value.
  always_ff @(posedge CLK) begin
    if (wr_commit_c && !RESET) begin
      if (!LDM) mem[wr_idx_c][7:0]  <= DQ_in[7:0];
      if (!UDM) mem[wr_idx_c][15:8] <= DQ_in[15:8];
    end
  end

  // Write-first bypass when a commit lands on the word being read.
  always_comb begin
    rd_word_c = mem[idx_c];
    if (wr_commit_c && (wr_idx_c == idx_c)) begin
      if (!LDM) rd_word_c[7:0]  = DQ_in[7:0];
      if (!UDM) rd_word_c[15:8] = DQ_in[15:8];
    end
  end

  always_comb begin
    rfc_d = rfc_q;
    if (cmd_ok_c && cmd_c == CMD_REF) rfc_d = RFC_W'(tRFC);
    else if (rfc_q != '0)             rfc_d = rfc_q - RFC_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_vld_q     <= '0;
      for (int i = 0; i < CL; i++) rd_dat_q[i] <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      rfc_q        <= '0;
      refreshing_q <= 1'b0;
    end else begin
      rd_vld_q[0] <= rd_go_c;
      rd_dat_q[0] <= rd_go_c ? rd_word_c : '0;
      for (int i = 1; i < CL; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_dat_q[i] <= rd_dat_q[i-1];
      end
      err_q <= !cmd_ok_c;
      if (!cmd_ok_c) err_code_q <= code_c;
      rfc_q        <= rfc_d;
      refreshing_q <= (rfc_d != '0);
    end
  end

  assign DQ_out     = rd_dat_q[CL-1];
  assign DQ_valid   = rd_vld_q[CL-1];
  assign refreshing = refreshing_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Scoreboard bench for ddr3_cmd_responder: stimulus pushes expected reads and
// errors with their due cycle, a negedge monitor pops and compares them.
module tb_ddr3_cmd_responder;
  import ddr3_pkg::*;

  localparam int CL_T = 5;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic        CS = 1'b1, RAS = 1'b1, CAS = 1'b1, WE = 1'b1;
  logic [14:0] Addr_in = '0;
  logic [2:0]  BA_in = '0;
  logic        LDM = 1'b1, UDM = 1'b1;
  logic [15:0] DQ_in = '0;
  logic [15:0] DQ_out;
  logic        DQ_valid, refreshing, err;
  logic [7:0]  bank_open;
  logic [2:0]  err_code;

  ddr3_cmd_responder #(
    .CL(CL_T), .CWL(0), .tRCD(4), .tRP(4), .tRFC(10), .MEM_AW(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .Addr_in(Addr_in), .BA_in(BA_in), .LDM(LDM), .UDM(UDM), .DQ_in(DQ_in),
    .DQ_out(DQ_out), .DQ_valid(DQ_valid), .bank_open(bank_open),
    .refreshing(refreshing), .err(err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t rdq[$];
  exp_t errq[$];
  exp_t me, ee;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation, value and cycle.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (DQ_valid) begin
        if (rdq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dq_valid: got data 0x%0h at cycle %0d, required no strobe", DQ_out, cyc);
        end else begin
          me = rdq.pop_front();
          check("dq_out", DQ_out, me.val);
          check("dq_valid_cycle", cyc, me.due);
        end
      end
      if (err) begin
        if (errq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_err: got code %0d at cycle %0d, required no error", err_code, cyc);
        end else begin
          ee = errq.pop_front();
          check("err_code", err_code, ee.val);
          check("err_cycle", cyc, ee.due);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] a,
                       input logic [15:0] d, input logic ldm, input logic udm);
    CS = 1'b0; {RAS, CAS, WE} = c; BA_in = ba; Addr_in = a;
    DQ_in = d; LDM = ldm; UDM = udm;
    @(posedge CLK); #1;
    CS = 1'b1; {RAS, CAS, WE} = 3'b111; LDM = 1'b1; UDM = 1'b1;
  endtask

  task automatic nop(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic act(input logic [2:0] ba, input logic [14:0] row);
    issue(CMD_ACT, ba, row, 16'h0, 1'b1, 1'b1);
  endtask

  task automatic wr(input logic [2:0] ba, input logic [14:0] a, input logic [15:0] d,
                    input logic ldm, input logic udm);
    issue(CMD_WR, ba, a, d, ldm, udm);
  endtask

  task automatic rd(input logic [2:0] ba, input logic [14:0] a, input logic [15:0] exp);
    rdq.push_back('{exp, cyc + CL_T});
    issue(CMD_RD, ba, a, 16'h0, 1'b1, 1'b1);
  endtask

  task automatic bad(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] a,
                     input logic [2:0] code);
    errq.push_back('{16'(code), cyc + 1});
    issue(c, ba, a, 16'h0, 1'b1, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    check("rst_dq_out", DQ_out, 16'h0);
    check("rst_dq_valid", DQ_valid, 1'b0);
    check("rst_bank_open", bank_open, 8'h00);
    check("rst_refreshing", refreshing, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_code", err_code, 3'd0);

    // Basic write/read and byte masking on bank 0 row 1
    act(3'd0, 15'h0001); nop(3);
    wr(3'd0, 15'h0005, 16'hA5C3, 1'b0, 1'b0);
    rd(3'd0, 15'h0005, 16'hA5C3);
    wr(3'd0, 15'h0005, 16'h1234, 1'b1, 1'b0);
    rd(3'd0, 15'h0005, 16'h12C3);

    // Bank 1; column 0x17 aliases 0x07 since only col[2:0] indexes storage
    act(3'd1, 15'h0002); nop(3);
    wr(3'd1, 15'h0007, 16'hBEEF, 1'b0, 1'b0);
    wr(3'd1, 15'h0017, 16'h0F0F, 1'b0, 1'b1);
    rd(3'd1, 15'h0007, 16'hBE0F);
    rd(3'd0, 15'h0005, 16'h12C3);

    // Closed-bank and tRCD violations
    bad(CMD_RD, 3'd3, 15'h0005, ERR_NOT_ACTIVE);
    act(3'd3, 15'h0000); nop(1);
    bad(CMD_RD, 3'd3, 15'h0005, ERR_TRCD);

    // Auto-precharge write, then ACT during and after tRP
    wr(3'd0, 15'h0406, 16'h5A5A, 1'b0, 1'b0);
    check("ap_bank0_closed", bank_open[0], 1'b0);
    nop(1);
    bad(CMD_ACT, 3'd0, 15'h0001, ERR_ACT_PRECHG);
    nop(1);
    act(3'd0, 15'h0001);
    check("reopen_bank_open", bank_open, 8'b0000_1011);

    // Precharge all, refresh window, refresh with an open bank
    issue(CMD_PRE, 3'd0, 15'h0400, 16'h0, 1'b1, 1'b1);
    check("pre_all_bank_open", bank_open, 8'h00);
    nop(3);
    issue(CMD_REF, 3'd0, 15'h0000, 16'h0, 1'b1, 1'b1);
    check("ref_start", refreshing, 1'b1);
    bad(CMD_ACT, 3'd2, 15'h0003, ERR_REFRESHING);
    nop(8);
    check("ref_last_cycle", refreshing, 1'b1);
    nop(1);
    check("ref_done", refreshing, 1'b0);
    act(3'd2, 15'h0003);
    bad(CMD_REF, 3'd0, 15'h0000, ERR_REF_OPEN);
    check("bank2_open", bank_open, 8'h04);
    nop(1);
    check("err_pulse_over", err, 1'b0);
    check("err_code_held", err_code, 3'd5);

    // Reset with three reads in flight; data must survive
    nop(1);
    wr(3'd2, 15'h0001, 16'hC0DE, 1'b0, 1'b0);
    repeat (3) issue(CMD_RD, 3'd2, 15'h0001, 16'h0, 1'b1, 1'b1);
    RESET = 1'b1;
    nop(2);
    RESET = 1'b0;
    check("post_rst_bank_open", bank_open, 8'h00);
    check("post_rst_dq_valid", DQ_valid, 1'b0);
    check("post_rst_err_code", err_code, 3'd0);
    nop(8);
    act(3'd2, 15'h0003);
    act(3'd0, 15'h0001);
    nop(3);
    rd(3'd2, 15'h0001, 16'hC0DE);
    rd(3'd0, 15'h0005, 16'h12C3);
    rd(3'd0, 15'h0006, 16'h5A5A);

    nop(CL_T + 3);
    check("reads_outstanding", rdq.size(), 0);
    check("errs_outstanding", errq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
